// File: rtl/vga_pkg.sv
// Shared raster timing constants for the video pipeline (VESA 800x600@60, 40 MHz).
package vga_pkg;
  localparam int CNT_W        = 11;
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N counter with enable; exposes next value and a wrap strobe for chaining.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int N = VGA_H_TOTAL,
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  always_comb begin
    wrap      = en && (count == LAST);
    count_nxt = count;
    if (en) count_nxt = (count == LAST) ? '0 : count + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator; every flag is registered from the same
// next-count values as the counters, so the whole bundle describes one pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start,
  output logic             line_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_size_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the counter width");
  end

  localparam logic [CNT_W-1:0] HB_BEG = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VB_BEG = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;

  vga_wrap_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk(clk), .rst_n(rst_n), .en(pix_en),
    .count(hcount_out), .count_nxt(h_nxt), .wrap(h_wrap)
  );

  // Vertical only steps on the horizontal wrap, so vsync can only change there.
  vga_wrap_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk(clk), .rst_n(rst_n), .en(h_wrap),
    .count(vcount_out), .count_nxt(v_nxt), .wrap(v_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      hsync_out   <= ~H_POL;
      vsync_out   <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hblnk_out   <= h_nxt >= HB_BEG;
      vblnk_out   <= v_nxt >= VB_BEG;
      hsync_out   <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? H_POL : ~H_POL;
      vsync_out   <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? V_POL : ~V_POL;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-enable bench: a small-raster DUT, its inverted-polarity twin and a
// default 800x600 DUT are checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;
  localparam int SVA = 8,  SVF = 1, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  logic clk = 1'b0, rst_n = 1'b1, pix_en = 1'b0;
  logic [10:0] s_h, s_v, n_h, n_v, d_h, d_v;
  logic s_hs, s_hb, s_vs, s_vb, s_fs, s_ls;
  logic n_hs, n_hb, n_vs, n_vb, n_fs, n_ls;
  logic d_hs, d_hb, d_vs, d_vb, d_fs, d_ls;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount_out(s_h), .hsync_out(s_hs), .hblnk_out(s_hb),
    .vcount_out(s_v), .vsync_out(s_vs), .vblnk_out(s_vb),
    .frame_start(s_fs), .line_start(s_ls));

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                   .H_POL(1'b0), .V_POL(1'b0)) u_neg (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount_out(n_h), .hsync_out(n_hs), .hblnk_out(n_hb),
    .vcount_out(n_v), .vsync_out(n_vs), .vblnk_out(n_vb),
    .frame_start(n_fs), .line_start(n_ls));

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount_out(d_h), .hsync_out(d_hs), .hblnk_out(d_hb),
    .vcount_out(d_v), .vsync_out(d_vs), .vblnk_out(d_vb),
    .frame_start(d_fs), .line_start(d_ls));

  typedef struct packed {
    logic [10:0] h, v;
    logic hs, hb, vs, vb;
  } bnd_t;

  int    n_chk = 0, n_err = 0, cyc = 0;
  int    fs_prev = -1, fs_last = -1;
  longint k = 0;  // enabled pixel steps since reset release

  function automatic bnd_t ref_at(longint kk, int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp);
    bnd_t   r;
    int     ht = ha + hfp + hsw + hbp;
    int     vt = va + vfp + vsw + vbp;
    longint p  = kk % longint'(ht * vt);
    int     h  = int'(p % ht);
    int     v  = int'(p / ht);
    r.h  = 11'(h);
    r.v  = 11'(v);
    r.hb = (h >= ha);
    r.hs = (h >= ha + hfp) && (h < ha + hfp + hsw);
    r.vb = (v >= va);
    r.vs = (v >= va + vfp) && (v < va + vfp + vsw);
    return r;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input logic en);
    bnd_t e  = ref_at(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
    bnd_t d  = ref_at(k, VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
                      VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
    logic ls  = en && (e.h == 0);
    logic fs  = ls && (e.v == 0);
    logic dls = en && (d.h == 0);
    chk("s_hcount", s_h, e.h);   chk("s_vcount", s_v, e.v);
    chk("s_hsync", s_hs, e.hs);  chk("s_hblnk", s_hb, e.hb);
    chk("s_vsync", s_vs, e.vs);  chk("s_vblnk", s_vb, e.vb);
    chk("s_line_start", s_ls, ls); chk("s_frame_start", s_fs, fs);
    chk("n_hcount", n_h, e.h);   chk("n_hsync", n_hs, !e.hs);
    chk("n_vsync", n_vs, !e.vs); chk("n_frame_start", n_fs, fs);
    chk("d_hcount", d_h, d.h);   chk("d_vcount", d_v, d.v);
    chk("d_hsync", d_hs, d.hs);  chk("d_hblnk", d_hb, d.hb);
    chk("d_line_start", d_ls, dls);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_h"}, s_h, 0);    chk({tag, "_v"}, s_v, 0);
    chk({tag, "_hs"}, s_hs, 0);  chk({tag, "_vs"}, s_vs, 0);
    chk({tag, "_hb"}, s_hb, 0);  chk({tag, "_vb"}, s_vb, 0);
    chk({tag, "_fs"}, s_fs, 0);  chk({tag, "_ls"}, s_ls, 0);
    chk({tag, "_n_hs"}, n_hs, 1); chk({tag, "_n_vs"}, n_vs, 1);
    chk({tag, "_d_h"}, d_h, 0);  chk({tag, "_d_hs"}, d_hs, 0);
  endtask

  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    #1;
    cyc++;
    if (en) k++;
    if (s_fs) begin
      fs_prev = fs_last;
      fs_last = cyc;
    end
    check_all(en);
  endtask

  initial begin
    bnd_t e;
    int   guard;
    #2 rst_n = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset("rst");
    rst_n = 1'b1;
    k = 0;

    repeat (3) step(1'b1);
    chk("h_after3", s_h, 3);

    // continuous enable: covers default 1055->0 wrap and small-raster frames
    repeat (2200) step(1'b1);
    chk("frame_per_1x", fs_last - fs_prev, SHT * SVT);

    for (int i = 0; i < 1500; i++) step(i % 2 == 0);
    chk("frame_per_2x", fs_last - fs_prev, 2 * SHT * SVT);

    repeat (2000) step($urandom_range(0, 3) != 0);

    // walk into the overlap of hsync and vsync, then reset between edges
    guard = 0;
    e = ref_at(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
    while (!(e.h == 11'(SHA + SHF + 1) && e.v == 11'(SVA + SVF)) && guard < 2000) begin
      step(1'b1);
      e = ref_at(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
      guard++;
    end
    chk("reach_mid", guard < 2000, 1);
    chk("mid_hsync", s_hs, 1);
    chk("mid_vsync", s_vs, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    repeat (2) @(posedge clk);
    #1 check_reset("held");
    rst_n = 1'b1;
    k = 0;
    repeat (400) step($urandom_range(0, 1) != 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
